vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator; next generation of the fixed 640x480@60 controller. Produces registered sync, visible, and coordinate outputs for any mode set by parameters, with programmable sync polarity and a pixel clock enable for clock division. Adds line/frame start strobes and a look-ahead fetch coordinate so a frame-buffer or pattern source with fixed read latency lines up with `visible`. Sits between the pixel clock domain and the pixel source / DAC output stage.

---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen_raster_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing types, standard mode constants and decode helpers.
// Used by the raster counter, the timing generator top and its bench.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_visible;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29};

  function automatic int unsigned calc_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  // Sync pulse occupies the slot immediately after the front porch.
  function automatic logic sync_active(input int unsigned pos, input int unsigned vis,
                                       input int unsigned front, input int unsigned sync);
    return (pos >= vis + front) && (pos < vis + front + sync);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the timing generator to the pixel source / DAC stage.
interface vga_timing_gen_if #(
  parameter int COORD_W = 10
);
  logic               visible;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic               h_sync;
  logic               v_sync;
  logic               line_start;
  logic               frame_start;
  logic               fetch_valid;
  logic [COORD_W-1:0] fetch_col;
  logic [COORD_W-1:0] fetch_row;

  modport master (
    output visible, col, row, h_sync, v_sync, line_start, frame_start,
           fetch_valid, fetch_col, fetch_row
  );

  modport slave (
    input visible, col, row, h_sync, v_sync, line_start, frame_start,
          fetch_valid, fetch_col, fetch_row
  );
endinterface

// File: rtl/vga_timing_gen_raster_counter.sv
// Cascaded horizontal/vertical raster counter with tick enable and a configurable
// reset position; exports the position the next tick enters plus wrap flags.
module vga_raster_counter #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int          COORD_W = 10,
  parameter int unsigned H_INIT  = 799,
  parameter int unsigned V_INIT  = 524
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               ce,
  output logic [COORD_W-1:0] h_next,
  output logic [COORD_W-1:0] v_next,
  output logic               line_wrap,
  output logic               frame_wrap
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_RST  = COORD_W'(H_INIT);
  localparam logic [COORD_W-1:0] V_RST  = COORD_W'(V_INIT);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

  logic [COORD_W-1:0] h_cnt_reg;
  logic [COORD_W-1:0] v_cnt_reg;

  // Wrap flags describe the current position, so they mark the tick that enters col 0.
  always_comb begin
    line_wrap  = (h_cnt_reg == H_LAST);
    frame_wrap = line_wrap && (v_cnt_reg == V_LAST);
    h_next     = line_wrap ? '0 : h_cnt_reg + ONE;
    v_next     = v_cnt_reg;
    if (line_wrap) begin
      v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + ONE;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_reg <= H_RST;
      v_cnt_reg <= V_RST;
    end else if (ce) begin
      h_cnt_reg <= h_next;
      v_cnt_reg <= v_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: display and look-ahead fetch rasters,
// decoded into registered, mutually aligned sync/visible/coordinate outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = MODE_640X480_60.h_visible,
  parameter int unsigned H_FRONT    = MODE_640X480_60.h_front,
  parameter int unsigned H_SYNC     = MODE_640X480_60.h_sync,
  parameter int unsigned H_BACK     = MODE_640X480_60.h_back,
  parameter int unsigned V_VISIBLE  = MODE_640X480_60.v_visible,
  parameter int unsigned V_FRONT    = MODE_640X480_60.v_front,
  parameter int unsigned V_SYNC     = MODE_640X480_60.v_sync,
  parameter int unsigned V_BACK     = MODE_640X480_60.v_back,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int          COORD_W    = 10,
  parameter int unsigned LEAD       = 2
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             ce,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  logic [COORD_W-1:0] disp_h_next;
  logic [COORD_W-1:0] disp_v_next;
  logic               disp_line_wrap;
  logic               disp_frame_wrap;
  logic [COORD_W-1:0] fetch_h_next;
  logic [COORD_W-1:0] fetch_v_next;
  logic               fetch_line_wrap;
  logic               fetch_frame_wrap;
  logic               unused_fetch_wraps;

  // Display raster starts one tick before (0,0) so the first enabled tick enters the frame.
  vga_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .COORD_W (COORD_W),
    .H_INIT  (H_TOTAL - 1),
    .V_INIT  (V_TOTAL - 1)
  ) u_disp_counter (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .ce         (ce),
    .h_next     (disp_h_next),
    .v_next     (disp_v_next),
    .line_wrap  (disp_line_wrap),
    .frame_wrap (disp_frame_wrap)
  );

  // Fetch raster sits LEAD ticks ahead of the display raster, modulo the frame.
  vga_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .COORD_W (COORD_W),
    .H_INIT  (LEAD - 1),
    .V_INIT  (0)
  ) u_fetch_counter (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .ce         (ce),
    .h_next     (fetch_h_next),
    .v_next     (fetch_v_next),
    .line_wrap  (fetch_line_wrap),
    .frame_wrap (fetch_frame_wrap)
  );

  assign unused_fetch_wraps = fetch_line_wrap ^ fetch_frame_wrap;

  logic visible_next;
  logic h_sync_next;
  logic v_sync_next;
  logic fetch_valid_next;

  always_comb begin
    visible_next     = (32'(disp_h_next) < H_VISIBLE) && (32'(disp_v_next) < V_VISIBLE);
    fetch_valid_next = (32'(fetch_h_next) < H_VISIBLE) && (32'(fetch_v_next) < V_VISIBLE);
    h_sync_next      = sync_active(32'(disp_h_next), H_VISIBLE, H_FRONT, H_SYNC)
                       ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_next      = sync_active(32'(disp_v_next), V_VISIBLE, V_FRONT, V_SYNC)
                       ? V_SYNC_POL : ~V_SYNC_POL;
  end

  logic               visible_reg;
  logic [COORD_W-1:0] col_reg;
  logic [COORD_W-1:0] row_reg;
  logic               h_sync_reg;
  logic               v_sync_reg;
  logic               line_start_reg;
  logic               frame_start_reg;
  logic               fetch_valid_reg;
  logic [COORD_W-1:0] fetch_col_reg;
  logic [COORD_W-1:0] fetch_row_reg;

  // Level outputs load only on ticks; strobes are recomputed every clock so they last one cycle.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      visible_reg     <= 1'b0;
      col_reg         <= '0;
      row_reg         <= '0;
      h_sync_reg      <= ~H_SYNC_POL;
      v_sync_reg      <= ~V_SYNC_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      fetch_valid_reg <= 1'b0;
      fetch_col_reg   <= '0;
      fetch_row_reg   <= '0;
    end else begin
      line_start_reg  <= ce && disp_line_wrap;
      frame_start_reg <= ce && disp_frame_wrap;
      if (ce) begin
        visible_reg     <= visible_next;
        col_reg         <= disp_h_next;
        row_reg         <= disp_v_next;
        h_sync_reg      <= h_sync_next;
        v_sync_reg      <= v_sync_next;
        fetch_valid_reg <= fetch_valid_next;
        fetch_col_reg   <= fetch_h_next;
        fetch_row_reg   <= fetch_v_next;
      end
    end
  end

  assign vid.visible     = visible_reg;
  assign vid.col         = col_reg;
  assign vid.row         = row_reg;
  assign vid.h_sync      = h_sync_reg;
  assign vid.v_sync      = v_sync_reg;
  assign vid.line_start  = line_start_reg;
  assign vid.frame_start = frame_start_reg;
  assign vid.fetch_valid = fetch_valid_reg;
  assign vid.fetch_col   = fetch_col_reg;
  assign vid.fetch_row   = fetch_row_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode and a tiny 14x7 mode side by side.
module tb_vga_timing_gen;

  localparam int D_HT = 800;
  localparam int D_VT = 525;
  localparam int S_HT = 14;
  localparam int S_VT = 7;
  localparam int LEAD = 2;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b0;
  logic ce        = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if #(.COORD_W(10)) d_if ();
  vga_timing_gen_if #(.COORD_W(4))  s_if ();

  vga_timing_gen dut_def (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .ce        (ce),
    .vid       (d_if)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .COORD_W (4), .LEAD (LEAD)
  ) dut_small (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .ce        (ce),
    .vid       (s_if)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   d_c, d_r, s_c, s_r;
  logic last_ce  = 1'b0;

  always @(posedge pixel_clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL timeout cycles=%0d required=completion", cyc);
    $fatal(1, "bench timeout");
  end

  function automatic int fetch_c(input int c, input int r, input int ht, input int vt);
    int lin;
    lin = (r * ht + c + LEAD) % (ht * vt);
    return lin % ht;
  endfunction

  function automatic int fetch_r(input int c, input int r, input int ht, input int vt);
    int lin;
    lin = (r * ht + c + LEAD) % (ht * vt);
    return lin / ht;
  endfunction

  task automatic model_reset();
    d_c = D_HT - 1; d_r = D_VT - 1;
    s_c = S_HT - 1; s_r = S_VT - 1;
  endtask

  // One clock with the given ce; outputs are sampled 1 ns after the edge.
  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge pixel_clk);
    #1;
    last_ce = ce_v;
    if (ce_v) begin
      d_c++;
      if (d_c == D_HT) begin d_c = 0; d_r = (d_r + 1) % D_VT; end
      s_c++;
      if (s_c == S_HT) begin s_c = 0; s_r = (s_r + 1) % S_VT; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ce = 1'b0;
    model_reset();
    repeat (5) @(posedge pixel_clk);
    #1;
    checks++; if (d_if.col !== 10'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", d_if.col); end
    checks++; if (d_if.row !== 10'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", d_if.row); end
    checks++; if (d_if.visible !== 1'b0) begin failures++; $display("FAIL reset_visible got=%b exp=0", d_if.visible); end
    checks++; if (d_if.h_sync !== 1'b1) begin failures++; $display("FAIL reset_h_sync got=%b exp=1", d_if.h_sync); end
    checks++; if (d_if.v_sync !== 1'b1) begin failures++; $display("FAIL reset_v_sync got=%b exp=1", d_if.v_sync); end
    checks++; if (d_if.line_start !== 1'b0) begin failures++; $display("FAIL reset_line_start got=%b exp=0", d_if.line_start); end
    checks++; if (d_if.frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b exp=0", d_if.frame_start); end
    checks++; if (d_if.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid got=%b exp=0", d_if.fetch_valid); end
    checks++; if (d_if.fetch_col !== 10'd0) begin failures++; $display("FAIL reset_fetch_col got=%0d exp=0", d_if.fetch_col); end
    checks++; if (d_if.fetch_row !== 10'd0) begin failures++; $display("FAIL reset_fetch_row got=%0d exp=0", d_if.fetch_row); end
    checks++; if (s_if.h_sync !== 1'b0) begin failures++; $display("FAIL reset_small_h_sync got=%b exp=0", s_if.h_sync); end
    checks++; if (s_if.v_sync !== 1'b0) begin failures++; $display("FAIL reset_small_v_sync got=%b exp=0", s_if.v_sync); end
    reset = 1'b1;
    step(1'b1);
    checks++; if (d_if.col !== 10'd0 || d_if.row !== 10'd0) begin failures++; $display("FAIL first_pos got=(%0d,%0d) exp=(0,0)", d_if.col, d_if.row); end
    checks++; if (d_if.visible !== 1'b1) begin failures++; $display("FAIL first_visible got=%b exp=1", d_if.visible); end
    checks++; if (d_if.line_start !== 1'b1) begin failures++; $display("FAIL first_line_start got=%b exp=1", d_if.line_start); end
    checks++; if (d_if.frame_start !== 1'b1) begin failures++; $display("FAIL first_frame_start got=%b exp=1", d_if.frame_start); end
    checks++; if (d_if.fetch_col !== 10'd2 || d_if.fetch_row !== 10'd0) begin failures++; $display("FAIL first_fetch got=(%0d,%0d) exp=(2,0)", d_if.fetch_col, d_if.fetch_row); end
    checks++; if (s_if.frame_start !== 1'b1 || s_if.col !== 4'd0) begin failures++; $display("FAIL first_small got=col%0d fs%b exp=col0 fs1", s_if.col, s_if.frame_start); end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_hsync_line();
    int low_run = 0;
    int low_start = -1;
    int prev_ls = cyc;
    for (int n = 0; n < 1800; n++) begin
      step(1'b1);
      checks++; if (d_if.col !== 10'(d_c) || d_if.row !== 10'(d_r)) begin failures++; $display("FAIL pos got=(%0d,%0d) exp=(%0d,%0d)", d_if.col, d_if.row, d_c, d_r); end
      checks++; if (d_if.h_sync !== !(d_c >= 656 && d_c < 752)) begin failures++; $display("FAIL h_sync col=%0d got=%b", d_c, d_if.h_sync); end
      checks++; if (d_if.v_sync !== 1'b1) begin failures++; $display("FAIL v_sync_idle row=%0d got=%b exp=1", d_r, d_if.v_sync); end
      checks++; if (d_if.visible !== (d_c < 640 && d_r < 480)) begin failures++; $display("FAIL visible col=%0d got=%b", d_c, d_if.visible); end
      checks++; if (d_if.line_start !== (d_c == 0)) begin failures++; $display("FAIL line_start col=%0d got=%b", d_c, d_if.line_start); end
      checks++; if (d_if.frame_start !== (d_c == 0 && d_r == 0)) begin failures++; $display("FAIL frame_start col=%0d got=%b", d_c, d_if.frame_start); end
      checks++;
      if (d_if.fetch_col !== 10'(fetch_c(d_c, d_r, D_HT, D_VT)) || d_if.fetch_row !== 10'(fetch_r(d_c, d_r, D_HT, D_VT))) begin
        failures++;
        $display("FAIL fetch pos=(%0d,%0d) got=(%0d,%0d) exp=(%0d,%0d)", d_c, d_r, d_if.fetch_col, d_if.fetch_row,
                 fetch_c(d_c, d_r, D_HT, D_VT), fetch_r(d_c, d_r, D_HT, D_VT));
      end
      if (d_if.h_sync === 1'b0) begin
        if (low_run == 0) low_start = d_c;
        low_run++;
      end else if (low_run > 0) begin
        checks++; if (low_run != 96 || low_start != 656) begin failures++; $display("FAIL h_sync_pulse got=len%0d@%0d exp=len96@656", low_run, low_start); end
        low_run = 0;
      end
      if (d_if.line_start === 1'b1) begin
        checks++; if (cyc - prev_ls != 800) begin failures++; $display("FAIL line_period got=%0d exp=800", cyc - prev_ls); end
        prev_ls = cyc;
      end
    end
    $display("test_hsync_line done checks=%0d", checks);
  endtask

  task automatic test_ce_toggle();
    int ls_cnt = 0;
    int guard = 0;
    while (d_c != 790 && guard < 2000) begin step(1'b1); guard++; end
    checks++; if (d_c != 790) begin failures++; $display("FAIL ce_setup got=%0d exp=790", d_c); end
    for (int i = 0; i < 40; i++) begin
      step((i % 2) == 0);
      checks++; if (d_if.col !== 10'(d_c) || d_if.row !== 10'(d_r)) begin failures++; $display("FAIL ce_pos i=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, d_if.col, d_if.row, d_c, d_r); end
      checks++; if (d_if.line_start !== (last_ce && d_c == 0)) begin failures++; $display("FAIL ce_line_start i=%0d got=%b", i, d_if.line_start); end
      checks++; if (d_if.frame_start !== 1'b0) begin failures++; $display("FAIL ce_frame_start i=%0d got=%b exp=0", i, d_if.frame_start); end
      checks++; if (d_if.visible !== (d_c < 640 && d_r < 480)) begin failures++; $display("FAIL ce_visible i=%0d got=%b", i, d_if.visible); end
      checks++; if (d_if.fetch_col !== 10'(fetch_c(d_c, d_r, D_HT, D_VT))) begin failures++; $display("FAIL ce_fetch_col i=%0d got=%0d", i, d_if.fetch_col); end
      if (d_if.line_start === 1'b1) ls_cnt++;
    end
    checks++; if (ls_cnt != 1) begin failures++; $display("FAIL ce_line_strobe_count got=%0d exp=1", ls_cnt); end
    $display("test_ce_toggle done checks=%0d", checks);
  endtask

  task automatic test_small();
    int prev_fs = -1;
    int seen_wrap = 0;
    for (int n = 0; n < 2 * S_HT * S_VT + 4; n++) begin
      step(1'b1);
      checks++; if (s_if.col !== 4'(s_c) || s_if.row !== 4'(s_r)) begin failures++; $display("FAIL small_pos got=(%0d,%0d) exp=(%0d,%0d)", s_if.col, s_if.row, s_c, s_r); end
      checks++; if (s_if.h_sync !== (s_c == 10 || s_c == 11)) begin failures++; $display("FAIL small_h_sync col=%0d got=%b", s_c, s_if.h_sync); end
      checks++; if (s_if.v_sync !== (s_r == 5)) begin failures++; $display("FAIL small_v_sync row=%0d got=%b", s_r, s_if.v_sync); end
      checks++; if (s_if.visible !== (s_c < 8 && s_r < 4)) begin failures++; $display("FAIL small_visible pos=(%0d,%0d) got=%b", s_c, s_r, s_if.visible); end
      checks++; if (s_if.frame_start !== (s_c == 0 && s_r == 0)) begin failures++; $display("FAIL small_frame_start pos=(%0d,%0d) got=%b", s_c, s_r, s_if.frame_start); end
      checks++;
      if (s_if.fetch_col !== 4'(fetch_c(s_c, s_r, S_HT, S_VT)) || s_if.fetch_row !== 4'(fetch_r(s_c, s_r, S_HT, S_VT))) begin
        failures++;
        $display("FAIL small_fetch pos=(%0d,%0d) got=(%0d,%0d)", s_c, s_r, s_if.fetch_col, s_if.fetch_row);
      end
      checks++;
      if (s_if.fetch_valid !== (fetch_c(s_c, s_r, S_HT, S_VT) < 8 && fetch_r(s_c, s_r, S_HT, S_VT) < 4)) begin
        failures++;
        $display("FAIL small_fetch_valid pos=(%0d,%0d) got=%b", s_c, s_r, s_if.fetch_valid);
      end
      if (s_c == 13 && s_r == 6) begin
        seen_wrap++;
        checks++; if (s_if.fetch_col !== 4'd1 || s_if.fetch_row !== 4'd0) begin failures++; $display("FAIL small_last_fetch got=(%0d,%0d) exp=(1,0)", s_if.fetch_col, s_if.fetch_row); end
      end
      if (s_if.frame_start === 1'b1) begin
        if (prev_fs >= 0) begin
          checks++; if (cyc - prev_fs != 98) begin failures++; $display("FAIL small_frame_period got=%0d exp=98", cyc - prev_fs); end
        end
        prev_fs = cyc;
      end
    end
    checks++; if (seen_wrap < 2) begin failures++; $display("FAIL small_wrap_seen got=%0d exp>=2", seen_wrap); end
    $display("test_small done checks=%0d", checks);
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (d_c != 300 && guard < 2000) begin step(1'b1); guard++; end
    checks++; if (d_if.col !== 10'd300) begin failures++; $display("FAIL mid_setup got=%0d exp=300", d_if.col); end
    reset = 1'b0;
    #1;
    checks++; if (d_if.col !== 10'd0 || d_if.row !== 10'd0) begin failures++; $display("FAIL mid_reset_pos got=(%0d,%0d) exp=(0,0)", d_if.col, d_if.row); end
    checks++; if (d_if.visible !== 1'b0 || d_if.h_sync !== 1'b1) begin failures++; $display("FAIL mid_reset_levels got=vis%b hs%b exp=vis0 hs1", d_if.visible, d_if.h_sync); end
    checks++; if (d_if.fetch_col !== 10'd0 || d_if.fetch_row !== 10'd0) begin failures++; $display("FAIL mid_reset_fetch got=(%0d,%0d) exp=(0,0)", d_if.fetch_col, d_if.fetch_row); end
    checks++; if (s_if.col !== 4'd0 || s_if.h_sync !== 1'b0) begin failures++; $display("FAIL mid_reset_small got=col%0d hs%b exp=col0 hs0", s_if.col, s_if.h_sync); end
    @(posedge pixel_clk);
    #1;
    reset = 1'b1;
    model_reset();
    step(1'b1);
    checks++; if (d_if.col !== 10'd0 || d_if.row !== 10'd0) begin failures++; $display("FAIL restart_pos got=(%0d,%0d) exp=(0,0)", d_if.col, d_if.row); end
    checks++; if (d_if.frame_start !== 1'b1 || d_if.line_start !== 1'b1) begin failures++; $display("FAIL restart_strobes got=fs%b ls%b exp=fs1 ls1", d_if.frame_start, d_if.line_start); end
    checks++; if (d_if.fetch_col !== 10'd2 || d_if.fetch_row !== 10'd0) begin failures++; $display("FAIL restart_fetch got=(%0d,%0d) exp=(2,0)", d_if.fetch_col, d_if.fetch_row); end
    step(1'b1);
    checks++; if (d_if.col !== 10'd1 || d_if.frame_start !== 1'b0) begin failures++; $display("FAIL restart_next got=col%0d fs%b exp=col1 fs0", d_if.col, d_if.frame_start); end
    $display("test_mid_reset done checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_ce_toggle();
    test_small();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
